// File: rtl/intr_pkg.sv
// intr_pkg: shared types and helpers for the interrupt controller.
//   state_e  : controller FSM states (IDLE, TRAP, ISR)
//   CAUSE_W  : width of the CAUSE output
//   MAX_SRC  : largest supported number of interrupt sources
//   prio_enc : returns the lowest set index of a request vector
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    ISR  = 2'd2
  } state_e;

  localparam int CAUSE_W = 3;
  localparam int MAX_SRC = 8;

  // Walk from the top down so the last hit, i.e. the lowest index, wins.
  function automatic logic [CAUSE_W-1:0] prio_enc(input logic [MAX_SRC-1:0] req);
    logic [CAUSE_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = CAUSE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: synchroniser chain plus rising-edge detector for one interrupt line.
//   clk, rst : clock and asynchronous active-high reset
//   irq_in   : raw asynchronous interrupt line
//   rise     : one-cycle pulse when the synchronised line goes 0 -> 1
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw line in at bit 0; the top bit is the metastability-safe copy.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt front-end for the MCU.
//   CLK, RST     : clock and asynchronous active-high reset
//   IRQ          : raw interrupt lines, rising edge requests service
//   MIE          : global interrupt enable from the CSR block
//   INSTR_DONE   : instruction boundary pulse from the control unit
//   MRET         : mret executing, ends the active handler
//   INT_REQ      : combinational, a trap will be taken at the next boundary
//   INT_TAKEN    : one-cycle trap pulse to the CSR block
//   CSR_WE       : write-enable pulse coincident with INT_TAKEN
//   PC_SEL_TRAP  : one-cycle pulse selecting MTVEC in the PC mux
//   IN_ISR       : a handler is active
//   CAUSE        : index of the source being serviced
//   PENDING      : latched pending requests
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic               MIE,
  input  logic               INSTR_DONE,
  input  logic               MRET,
  output logic               INT_REQ,
  output logic               INT_TAKEN,
  output logic               CSR_WE,
  output logic               PC_SEL_TRAP,
  output logic               IN_ISR,
  output logic [CAUSE_W-1:0] CAUSE,
  output logic [NUM_SRC-1:0] PENDING
);

  logic [NUM_SRC-1:0] rise_vec;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] clr_mask;
  logic [MAX_SRC-1:0] pend_ext;
  logic [CAUSE_W-1:0] winner;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  state_e             state_q, state_d;
  logic               trap_pulse_q, trap_pulse_d;
  logic               in_isr_q, in_isr_d;
  logic               int_req;
  logic               take;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
      .clk   (CLK),
      .rst   (RST),
      .irq_in(IRQ[g]),
      .rise  (rise_vec[g])
    );
  end

  // Arbitration, pending update and FSM next-state. A fresh edge on the
  // source being cleared is OR'd in after the clear so it is never lost.
  always_comb begin
    pend_ext               = '0;
    pend_ext[NUM_SRC-1:0]  = pending_q;
    winner                 = prio_enc(pend_ext);
    int_req                = (state_q == IDLE) & MIE & (|pending_q);
    take                   = int_req & INSTR_DONE;

    clr_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take && (winner == CAUSE_W'(i))) clr_mask[i] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask) | rise_vec;

    state_d      = state_q;
    cause_d      = cause_q;
    trap_pulse_d = 1'b0;
    in_isr_d     = in_isr_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d      = TRAP;
          cause_d      = winner;
          trap_pulse_d = 1'b1;
        end
      end
      TRAP: begin
        state_d  = ISR;
        in_isr_d = 1'b1;
      end
      ISR: begin
        if (MRET) begin
          state_d  = IDLE;
          in_isr_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        in_isr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      cause_q      <= '0;
      trap_pulse_q <= 1'b0;
      in_isr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cause_q      <= cause_d;
      trap_pulse_q <= trap_pulse_d;
      in_isr_q     <= in_isr_d;
    end
  end

  assign INT_REQ     = int_req;
  assign INT_TAKEN   = trap_pulse_q;
  assign CSR_WE      = trap_pulse_q;
  assign PC_SEL_TRAP = trap_pulse_q;
  assign IN_ISR      = in_isr_q;
  assign CAUSE       = cause_q;
  assign PENDING     = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl (NUM_SRC=4, SYNC_STAGES=2).
module tb_intr_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] IRQ = 4'b0;
  logic       MIE = 1'b0;
  logic       INSTR_DONE = 1'b0;
  logic       MRET = 1'b0;
  logic       INT_REQ, INT_TAKEN, CSR_WE, PC_SEL_TRAP, IN_ISR;
  logic [2:0] CAUSE;
  logic [3:0] PENDING;

  int checks   = 0;
  int failures = 0;

  intr_ctrl #(
    .NUM_SRC    (4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IRQ        (IRQ),
    .MIE        (MIE),
    .INSTR_DONE (INSTR_DONE),
    .MRET       (MRET),
    .INT_REQ    (INT_REQ),
    .INT_TAKEN  (INT_TAKEN),
    .CSR_WE     (CSR_WE),
    .PC_SEL_TRAP(PC_SEL_TRAP),
    .IN_ISR     (IN_ISR),
    .CAUSE      (CAUSE),
    .PENDING    (PENDING)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge, where outputs have settled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The three trap pulses must always move together.
  task automatic checkPulses(input string tag, input logic exp);
    checkOutput({tag, "_int_taken"}, {7'b0, INT_TAKEN}, {7'b0, exp});
    checkOutput({tag, "_csr_we"}, {7'b0, CSR_WE}, {7'b0, exp});
    checkOutput({tag, "_pc_sel"}, {7'b0, PC_SEL_TRAP}, {7'b0, exp});
  endtask

  initial begin
    $display("[TB] start");

    // Reset mid-cycle with no clock edge in between.
    #3 RST = 1'b1;
    #1;
    checkOutput("rst_pending", {4'b0, PENDING}, 8'h0);
    checkOutput("rst_int_req", {7'b0, INT_REQ}, 8'h0);
    checkOutput("rst_in_isr", {7'b0, IN_ISR}, 8'h0);
    checkOutput("rst_cause", {5'b0, CAUSE}, 8'h0);
    checkPulses("rst", 1'b0);
    tick();
    RST = 1'b0;

    // Single interrupt: IRQ[2] sampled at edge n, pending after edge n+2, trap at n+3.
    MIE = 1'b1;
    INSTR_DONE = 1'b1;
    IRQ = 4'b0100;
    tick();
    checkOutput("lat_e1_pending", {4'b0, PENDING}, 8'h0);
    tick();
    checkOutput("lat_e2_pending", {4'b0, PENDING}, 8'h0);
    checkOutput("lat_e2_int_req", {7'b0, INT_REQ}, 8'h0);
    tick();
    checkOutput("lat_e3_pending", {4'b0, PENDING}, 8'h4);
    checkOutput("lat_e3_int_req", {7'b0, INT_REQ}, 8'h1);
    tick();
    checkPulses("lat_trap", 1'b1);
    checkOutput("lat_trap_cause", {5'b0, CAUSE}, 8'h2);
    checkOutput("lat_trap_pending", {4'b0, PENDING}, 8'h0);
    checkOutput("lat_trap_in_isr", {7'b0, IN_ISR}, 8'h0);
    tick();
    checkPulses("lat_isr", 1'b0);
    checkOutput("lat_isr_in_isr", {7'b0, IN_ISR}, 8'h1);
    tick();
    tick();
    checkOutput("lat_level_once", {4'b0, PENDING}, 8'h0);
    MRET = 1'b1;
    tick();
    MRET = 1'b0;
    checkOutput("lat_mret_in_isr", {7'b0, IN_ISR}, 8'h0);
    checkOutput("lat_mret_int_req", {7'b0, INT_REQ}, 8'h0);
    IRQ = 4'b0;
    INSTR_DONE = 1'b0;
    repeat (4) tick();

    // Priority and queueing: IRQ[3] and IRQ[1] together.
    IRQ = 4'b1010;
    repeat (3) tick();
    checkOutput("prio_pending", {4'b0, PENDING}, 8'hA);
    checkOutput("prio_int_req", {7'b0, INT_REQ}, 8'h1);
    INSTR_DONE = 1'b1;
    tick();
    INSTR_DONE = 1'b0;
    checkPulses("prio_trap1", 1'b1);
    checkOutput("prio_cause1", {5'b0, CAUSE}, 8'h1);
    checkOutput("prio_pending1", {4'b0, PENDING}, 8'h8);
    tick();
    checkOutput("prio_in_isr1", {7'b0, IN_ISR}, 8'h1);
    checkOutput("prio_no_req_isr", {7'b0, INT_REQ}, 8'h0);
    MRET = 1'b1;
    tick();
    MRET = 1'b0;
    checkOutput("prio_after_mret", {7'b0, IN_ISR}, 8'h0);
    checkOutput("prio_req2", {7'b0, INT_REQ}, 8'h1);
    INSTR_DONE = 1'b1;
    tick();
    INSTR_DONE = 1'b0;
    checkPulses("prio_trap2", 1'b1);
    checkOutput("prio_cause2", {5'b0, CAUSE}, 8'h3);
    checkOutput("prio_pending2", {4'b0, PENDING}, 8'h0);
    tick();
    checkOutput("prio_in_isr2", {7'b0, IN_ISR}, 8'h1);
    MRET = 1'b1;
    tick();
    MRET = 1'b0;
    IRQ = 4'b0;
    repeat (4) tick();

    // Masking: MIE low keeps the request latched but never traps.
    MIE = 1'b0;
    IRQ = 4'b0001;
    repeat (3) tick();
    checkOutput("mask_pending", {4'b0, PENDING}, 8'h1);
    checkOutput("mask_int_req", {7'b0, INT_REQ}, 8'h0);
    for (int i = 0; i < 20; i++) begin
      INSTR_DONE = (i % 2 == 0);
      tick();
      checkOutput("mask_no_trap", {7'b0, INT_TAKEN}, 8'h0);
    end
    INSTR_DONE = 1'b0;
    checkOutput("mask_still_pending", {4'b0, PENDING}, 8'h1);
    MIE = 1'b1;
    #1;
    checkOutput("mask_mie_rise_req", {7'b0, INT_REQ}, 8'h1);
    MIE = 1'b0;
    #1;
    checkOutput("mask_mie_fall_req", {7'b0, INT_REQ}, 8'h0);
    MIE = 1'b1;
    INSTR_DONE = 1'b1;
    tick();
    INSTR_DONE = 1'b0;
    IRQ = 4'b0;
    checkPulses("mask_trap", 1'b1);
    checkOutput("mask_cause", {5'b0, CAUSE}, 8'h0);
    tick();
    checkOutput("mask_in_isr", {7'b0, IN_ISR}, 8'h1);

    // No nesting: a pulse on IRQ[0] while in the handler waits for MRET.
    INSTR_DONE = 1'b1;
    IRQ = 4'b0001;
    tick();
    IRQ = 4'b0;
    tick();
    tick();
    checkOutput("nest_pending", {4'b0, PENDING}, 8'h1);
    tick();
    checkOutput("nest_no_trap", {7'b0, INT_TAKEN}, 8'h0);
    checkOutput("nest_still_isr", {7'b0, IN_ISR}, 8'h1);
    MRET = 1'b1;
    tick();
    MRET = 1'b0;
    checkOutput("nest_mret_in_isr", {7'b0, IN_ISR}, 8'h0);
    checkOutput("nest_req", {7'b0, INT_REQ}, 8'h1);
    tick();
    INSTR_DONE = 1'b0;
    checkPulses("nest_trap", 1'b1);
    checkOutput("nest_cause", {5'b0, CAUSE}, 8'h0);
    tick();
    MRET = 1'b1;
    tick();
    MRET = 1'b0;

    // Set wins: second edge on IRQ[1] lands on the edge that clears PENDING[1].
    IRQ = 4'b0010;
    repeat (3) tick();
    checkOutput("setwin_first", {4'b0, PENDING}, 8'h2);
    IRQ = 4'b0;
    repeat (3) tick();
    IRQ = 4'b0010;
    tick();
    tick();
    INSTR_DONE = 1'b1;
    tick();
    INSTR_DONE = 1'b0;
    checkPulses("setwin_trap", 1'b1);
    checkOutput("setwin_cause", {5'b0, CAUSE}, 8'h1);
    checkOutput("setwin_pending", {4'b0, PENDING}, 8'h2);
    tick();
    checkOutput("setwin_in_isr", {7'b0, IN_ISR}, 8'h1);

    // Reset while in the handler.
    IRQ = 4'b0;
    #2 RST = 1'b1;
    #1;
    checkOutput("rst_isr_in_isr", {7'b0, IN_ISR}, 8'h0);
    checkOutput("rst_isr_pending", {4'b0, PENDING}, 8'h0);
    checkOutput("rst_isr_cause", {5'b0, CAUSE}, 8'h0);
    checkOutput("rst_isr_int_req", {7'b0, INT_REQ}, 8'h0);
    tick();
    RST = 1'b0;

    // Reset during the TRAP cycle cancels the pulse at once.
    IRQ = 4'b1000;
    INSTR_DONE = 1'b1;
    repeat (4) tick();
    checkPulses("rst_trap_pre", 1'b1);
    checkOutput("rst_trap_pre_cause", {5'b0, CAUSE}, 8'h3);
    IRQ = 4'b0;
    INSTR_DONE = 1'b0;
    #2 RST = 1'b1;
    #1;
    checkPulses("rst_trap", 1'b0);
    checkOutput("rst_trap_cause", {5'b0, CAUSE}, 8'h0);
    checkOutput("rst_trap_in_isr", {7'b0, IN_ISR}, 8'h0);
    tick();
    RST = 1'b0;
    tick();
    checkPulses("rst_trap_after", 1'b0);
    checkOutput("rst_trap_after_isr", {7'b0, IN_ISR}, 8'h0);

    // Stray MRET in IDLE does nothing; the controller still traps afterwards.
    MRET = 1'b1;
    tick();
    MRET = 1'b0;
    checkOutput("stray_mret_isr", {7'b0, IN_ISR}, 8'h0);
    checkOutput("stray_mret_req", {7'b0, INT_REQ}, 8'h0);
    IRQ = 4'b0100;
    INSTR_DONE = 1'b1;
    repeat (4) tick();
    checkPulses("post_rst_trap", 1'b1);
    checkOutput("post_rst_cause", {5'b0, CAUSE}, 8'h2);
    INSTR_DONE = 1'b0;
    IRQ = 4'b0;
    tick();
    checkOutput("post_rst_in_isr", {7'b0, IN_ISR}, 8'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt front-end for the MCU: synchronises NUM_SRC asynchronous interrupt lines and detects rising edges.
- Latches pending requests and arbitrates them by fixed priority, gated by the CSR MIE bit.
- Sequences trap entry with the control unit at instruction boundaries.
- Drives the CSR block's INT_TAKEN/WE pair so the CSR saves PC into MEPC and clears MIE; tracks the handler until MRET.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..8).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IRQ  in  NUM_SRC  raw asynchronous interrupt lines; a rising edge requests service.
- MIE  in  1  global enable, from the CSR MIE output.
- INSTR_DONE  in  1  control unit pulse: the current instruction retires this cycle (boundary).
- MRET  in  1  control unit pulse: an mret is executing.
- INT_REQ  out  1  combinational: an interrupt will be taken at the next INSTR_DONE.
- INT_TAKEN  out  1  one-cycle pulse to the CSR INT_TAKEN input.
- CSR_WE  out  1  one-cycle pulse coincident with INT_TAKEN; OR'd into the CSR WE input by the top level.
- PC_SEL_TRAP  out  1  one-cycle pulse; selects MTVEC in the PC mux.
- IN_ISR  out  1  high while a handler is active.
- CAUSE  out  3  index of the source being serviced.
- PENDING  out  NUM_SRC  pending-flag vector, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately): synchroniser and edge flops cleared, PENDING=0, state=IDLE, CAUSE=0. All pulse outputs are 0 and IN_ISR=0.
- Synchroniser: each IRQ[i] passes through SYNC_STAGES flops, then one edge-detect flop. PENDING[i] sets on the clock where sync_out=1 and prev=0.
  - Latency: an IRQ high at the sampling edge n appears in PENDING after edge n+SYNC_STAGES (visible in cycle n+SYNC_STAGES+1).
  - A level held high produces only one edge and sets PENDING once.
- Priority: the winner is the lowest index i with PENDING[i]=1.
- INT_REQ = (state==IDLE) & MIE & |PENDING.
- FSM states: IDLE, TRAP, ISR.
  - IDLE -> TRAP when INT_REQ & INSTR_DONE. On this edge CAUSE <= winner and PENDING[winner] is cleared.
  - TRAP lasts exactly 1 cycle, with INT_TAKEN=CSR_WE=PC_SEL_TRAP=1. It always moves to ISR and ignores all inputs.
  - ISR: IN_ISR=1 and no new trap is taken (no nesting); new edges still set PENDING. ISR -> IDLE on MRET.
  - MRET in IDLE or TRAP is ignored.
- Simultaneous events:
  - A new edge on source i on the same edge that clears PENDING[i]: the set wins and PENDING[i] stays 1.
  - INSTR_DONE with MIE=0: no trap; pending requests remain latched.
  - MIE falling while in IDLE with PENDING set: INT_REQ drops the same cycle.
- Reset during TRAP or ISR returns to IDLE at once. No pulse completes after reset asserts.
- Width: CAUSE is zero-extended from clog2(NUM_SRC). Unused upper bits are 0.
- Outputs are registered except INT_REQ.

Decomposition:
- Package intr_pkg holds:
  - the state enum (IDLE, TRAP, ISR),
  - CAUSE_W=3,
  - MAX_SRC=8,
  - a priority-encode function returning the lowest set index.
- Sub-module irq_sync (parameter SYNC_STAGES): one synchroniser chain plus edge detect, outputting a one-cycle rise pulse. Instantiated NUM_SRC times with a generate loop.
- Pending register, arbiter and FSM live in intr_ctrl.

Test Plan:
- Reset then idle:
  - Stimulus: RST pulse mid-cycle, IRQ=0.
  - Required: PENDING=0, INT_REQ=0, IN_ISR=0 immediately, with no clock edge needed.
- Single interrupt latency:
  - Stimulus: MIE=1, raise IRQ[2] at edge 10, INSTR_DONE held 1.
  - Required: PENDING[2]=1 after edge 12, INT_REQ high. TRAP at edge 13 gives INT_TAKEN=CSR_WE=PC_SEL_TRAP=1 for one cycle and CAUSE=2. Then IN_ISR=1.
- Priority and queueing:
  - Stimulus: IRQ[3] and IRQ[1] rise together, full trap and MRET sequence.
  - Required: CAUSE=1 first. After MRET, a second trap is taken with CAUSE=3.
- Masking:
  - Stimulus: MIE=0 with an IRQ[0] edge, INSTR_DONE pulsing for 20 cycles.
  - Required: no INT_TAKEN and PENDING[0] stays 1. When MIE goes to 1, the trap is taken at the next INSTR_DONE.
- No nesting and set-wins:
  - Stimulus: in ISR, pulse IRQ[0].
  - Required: no trap until MRET, then CAUSE=0. Separately, an edge coincident with the clear leaves PENDING[i]=1.
- Reset mid-handler:
  - Stimulus: assert RST in TRAP and in ISR.
  - Required: outputs return to 0 and the state is IDLE. A stray MRET in IDLE has no effect.
